// File: rtl/enc_pwm_mixer_n.sv
// rtl/enc_pwm_mixer_n.sv - N-channel rotary encoder to PWM level mixer
// Debounced detents adjust per-channel levels; duty is latched at each PWM period boundary.
module enc_pwm_mixer_n #(
    parameter int CHANNELS     = 3,
    parameter int PWM_WIDTH    = 8,
    parameter int DEBOUNCE_DIV = 4,
    parameter int STEP         = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic                          wrap_mode,
    input  logic [CHANNELS-1:0]           enc_a,
    input  logic [CHANNELS-1:0]           enc_b,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic [CHANNELS*PWM_WIDTH-1:0] level
);

    localparam logic [PWM_WIDTH-1:0] MAX_LVL = '1;
    localparam logic [PWM_WIDTH-1:0] ONE     = PWM_WIDTH'(1);
    localparam logic [PWM_WIDTH:0]   STEP_W  = (PWM_WIDTH+1)'(STEP);

    logic [CHANNELS-1:0]  a_s1, a_s2, b_s1, b_s2;
    logic [CHANNELS-1:0]  a_db, b_db, a_prev;
    logic                 strobe;
    logic [CHANNELS-1:0]  detent;
    logic [PWM_WIDTH-1:0] lvl      [CHANNELS];
    logic [PWM_WIDTH-1:0] lvl_next [CHANNELS];
    logic [PWM_WIDTH-1:0] duty     [CHANNELS];
    logic [PWM_WIDTH:0]   sum      [CHANNELS];
    logic [PWM_WIDTH:0]   diff     [CHANNELS];
    logic [PWM_WIDTH-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1 <= '0;
            a_s2 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            a_s1 <= enc_a;
            a_s2 <= a_s1;
            b_s1 <= enc_b;
            b_s2 <= b_s1;
        end
    end

    generate
        if (DEBOUNCE_DIV == 0) begin : g_no_presc
            assign strobe = 1'b1;
        end else begin : g_presc
            localparam logic [DEBOUNCE_DIV-1:0] P_ONE = DEBOUNCE_DIV'(1);
            logic [DEBOUNCE_DIV-1:0] presc;
            always_ff @(posedge clk) begin
                if (reset) presc <= '0;
                else       presc <= presc + P_ONE;
            end
            assign strobe = &presc;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            a_db   <= '0;
            b_db   <= '0;
            a_prev <= '0;
        end else if (strobe) begin
            a_db   <= a_s2;
            b_db   <= b_s2;
            a_prev <= a_db;
        end
    end

    assign detent = {CHANNELS{strobe}} & a_db & ~a_prev;

    // One extra bit catches overflow/borrow so saturation sees the true result.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]  = {1'b0, lvl[i]} + STEP_W;
            diff[i] = {1'b0, lvl[i]} - STEP_W;
            lvl_next[i] = lvl[i];
            if (detent[i]) begin
                if (b_db[i])
                    lvl_next[i] = (diff[i][PWM_WIDTH] && !wrap_mode) ? '0 : diff[i][PWM_WIDTH-1:0];
                else
                    lvl_next[i] = (sum[i][PWM_WIDTH] && !wrap_mode) ? MAX_LVL : sum[i][PWM_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl[i]  <= '0;
                duty[i] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + ONE;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl[i]     <= lvl_next[i];
                pwm_out[i] <= ena & (pwm_cnt < duty[i]);
                if (pwm_cnt == MAX_LVL)
                    duty[i] <= lvl[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_level
            assign level[g*PWM_WIDTH +: PWM_WIDTH] = lvl[g];
        end
    endgenerate

endmodule

// File: tb/tb_enc_pwm_mixer_n.sv
// tb/tb_enc_pwm_mixer_n.sv - scoreboard bench for enc_pwm_mixer_n (debounce 0 and 4 instances)
module tb_enc_pwm_mixer_n;
    localparam int CH = 3;
    localparam int PW = 8;
    localparam int M  = 256;
    localparam int ST = 1;

    logic          clk = 1'b0;
    logic          reset, ena, wrap_mode;
    logic [CH-1:0] enc_a, enc_b;
    logic [CH-1:0] pwm0, pwm4;
    logic [CH*PW-1:0] lv0, lv4;

    typedef struct {
        logic [CH*PW-1:0] lv0;
        logic [CH-1:0]    p0;
        logic [CH*PW-1:0] lv4;
        logic [CH-1:0]    p4;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc_pwm_mixer_n #(.CHANNELS(CH), .PWM_WIDTH(PW), .DEBOUNCE_DIV(0), .STEP(ST)) dut0 (
        .clk(clk), .reset(reset), .ena(ena), .wrap_mode(wrap_mode),
        .enc_a(enc_a), .enc_b(enc_b), .pwm_out(pwm0), .level(lv0));

    enc_pwm_mixer_n #(.CHANNELS(CH), .PWM_WIDTH(PW), .DEBOUNCE_DIV(4), .STEP(ST)) dut4 (
        .clk(clk), .reset(reset), .ena(ena), .wrap_mode(wrap_mode),
        .enc_a(enc_a), .enc_b(enc_b), .pwm_out(pwm4), .level(lv4));

    // Reference model: index 0 = no debounce prescaler, 1 = 16-clk sample period
    logic [CH-1:0] s1a[2], s2a[2], s1b[2], s2b[2], dba[2], dbb[2], pva[2], mpwm[2];
    int lvl[2][CH];
    int duty[2][CH];
    int cnt[2];
    int ph[2];

    function automatic int apply_step(int l, logic down, logic wrap);
        int n;
        if (down) begin
            n = l - ST;
            if (n < 0) n = wrap ? n + M : 0;
        end else begin
            n = l + ST;
            if (n > M - 1) n = wrap ? n - M : M - 1;
        end
        return n;
    endfunction

    task automatic model_edge();
        int per;
        for (int d = 0; d < 2; d++) begin
            per = (d == 0) ? 1 : 16;
            if (reset) begin
                ph[d] = 0; cnt[d] = 0; mpwm[d] = '0;
                s1a[d] = '0; s2a[d] = '0; s1b[d] = '0; s2b[d] = '0;
                dba[d] = '0; dbb[d] = '0; pva[d] = '0;
                for (int c = 0; c < CH; c++) begin
                    lvl[d][c] = 0;
                    duty[d][c] = 0;
                end
            end else begin
                for (int c = 0; c < CH; c++) mpwm[d][c] = ena && (cnt[d] < duty[d][c]);
                if (cnt[d] == M - 1)
                    for (int c = 0; c < CH; c++) duty[d][c] = lvl[d][c];
                if (ph[d] == per - 1) begin
                    for (int c = 0; c < CH; c++)
                        if (dba[d][c] && !pva[d][c])
                            lvl[d][c] = apply_step(lvl[d][c], dbb[d][c], wrap_mode);
                    pva[d] = dba[d];
                    dba[d] = s2a[d];
                    dbb[d] = s2b[d];
                end
                s2a[d] = s1a[d]; s2b[d] = s1b[d];
                s1a[d] = enc_a;  s1b[d] = enc_b;
                cnt[d] = (cnt[d] + 1) % M;
                ph[d]  = (ph[d] + 1) % per;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        for (int c = 0; c < CH; c++) begin
            e.lv0[c*PW +: PW] = 8'(lvl[0][c]);
            e.lv4[c*PW +: PW] = 8'(lvl[1][c]);
        end
        e.p0 = mpwm[0];
        e.p4 = mpwm[1];
        @(posedge clk);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic detent(int ch, logic down, int hi, int lo);
        enc_b[ch] = down;
        enc_a[ch] = 1'b1;
        repeat (hi) tick();
        enc_a[ch] = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enc_a = '0;
        enc_b = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (lv0 !== e.lv0) begin errors++; $display("FAIL sb_level_div0 got %h expected %h", lv0, e.lv0); end
                if (pwm0 !== e.p0) begin errors++; $display("FAIL sb_pwm_div0 got %b expected %b", pwm0, e.p0); end
                if (lv4 !== e.lv4) begin errors++; $display("FAIL sb_level_div4 got %h expected %h", lv4, e.lv4); end
                if (pwm4 !== e.p4) begin errors++; $display("FAIL sb_pwm_div4 got %b expected %b", pwm4, e.p4); end
            end
        end
    end

    initial begin : stim
        int base, highs;
        reset = 1'b1; ena = 1'b1; wrap_mode = 1'b0;
        enc_a = CH'($urandom); enc_b = CH'($urandom);
        @(negedge clk);

        // Reset with random encoder inputs
        tick();
        check("reset_level_e1", int'(lv0), 0);
        check("reset_pwm_e1", int'(pwm0), 0);
        enc_a = CH'($urandom); enc_b = CH'($urandom);
        tick();
        check("reset_level_e2", int'(lv4), 0);
        check("reset_pwm_e2", int'(pwm4), 0);
        reset = 1'b0; enc_a = '0; enc_b = '0;
        repeat (4) tick();

        // Increment ch1 with latency measurement
        enc_b[1] = 1'b0;
        enc_a[1] = 1'b1;
        repeat (3) tick();
        check("latency_before_4", int'(lv0[PW +: PW]), 0);
        tick();
        check("latency_at_4", int'(lv0[PW +: PW]), 1);
        enc_a[1] = 1'b0;
        repeat (4) tick();
        repeat (9) detent(1, 1'b0, 4, 4);
        check("inc_ch1", int'(lv0[PW +: PW]), 10);
        check("inc_ch0", int'(lv0[0 +: PW]), 0);
        check("inc_ch2", int'(lv0[2*PW +: PW]), 0);

        // Saturate then wrap on ch0
        do_reset();
        repeat (254) detent(0, 1'b0, 4, 4);
        check("preset_254", int'(lv0[0 +: PW]), 254);
        repeat (3) detent(0, 1'b0, 4, 4);
        check("sat_up", int'(lv0[0 +: PW]), 255);
        repeat (300) detent(0, 1'b1, 4, 4);
        check("sat_down", int'(lv0[0 +: PW]), 0);
        wrap_mode = 1'b1;
        detent(0, 1'b1, 4, 4);
        check("wrap_down", int'(lv0[0 +: PW]), 255);
        detent(0, 1'b1, 4, 4);
        repeat (3) detent(0, 1'b0, 4, 4);
        check("wrap_up", int'(lv0[0 +: PW]), 1);
        wrap_mode = 1'b0;

        // PWM duty on ch2
        do_reset();
        repeat (64) detent(2, 1'b0, 4, 4);
        check("duty_level", int'(lv0[2*PW +: PW]), 64);
        repeat (512) tick();
        highs = 0;
        for (int k = 0; k < M; k++) begin
            tick();
            if (pwm0[2]) highs++;
        end
        check("duty_high_cycles", highs, 64);
        ena = 1'b0;
        tick();
        check("ena_off_div0", int'(pwm0), 0);
        check("ena_off_div4", int'(pwm4), 0);
        repeat (20) tick();
        ena = 1'b1;

        // Debounce on the prescaled instance
        do_reset();
        base = int'(lv4[0 +: PW]);
        for (int k = 0; k < 4; k++) begin
            enc_a[0] = (k % 2 == 0);
            repeat (3) tick();
        end
        enc_a[0] = 1'b1;
        repeat (40) tick();
        check("bounce_at_most_one", (int'(lv4[0 +: PW]) - base) <= ST, 1);
        enc_a[0] = 1'b0;
        repeat (40) tick();
        base = int'(lv4[0 +: PW]);
        detent(0, 1'b0, 40, 40);
        check("clean_detent_div4", int'(lv4[0 +: PW]) - base, ST);

        // Reset mid-operation
        do_reset();
        repeat (100) detent(0, 1'b0, 4, 4);
        check("preset_100", int'(lv0[0 +: PW]), 100);
        enc_a[0] = 1'b1;
        tick();
        reset = 1'b1;
        enc_a[0] = 1'b0;
        tick();
        check("midreset_level", int'(lv0), 0);
        check("midreset_pwm", int'(pwm0), 0);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("midreset_no_detent", int'(lv0[0 +: PW]), 0);
        detent(0, 1'b0, 4, 4);
        check("post_reset_detent", int'(lv0[0 +: PW]), ST);

        // Random encoder activity, mode and enable changes
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) enc_a[c] = ~enc_a[c];
                if ($urandom_range(7) == 0) enc_b[c] = ~enc_b[c];
            end
            if ($urandom_range(199) == 0) wrap_mode = ~wrap_mode;
            if ($urandom_range(299) == 0) ena = ~ena;
            tick();
        end

        repeat (2) tick();
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
